// File: rtl/mem_port_arbiter.sv
// Single memory bus port shared by instruction fetch and load/store, with one-cycle valid pulses.
// The bus wait-timeout with bus_err is compiled in only when MEM_PORT_ARBITER_TIMEOUT_EN is defined.
// state  | meaning
// IDLE   | arbitrate between fetch and data requests
// BUS_D  | data access outstanding on the bus
// BUS_I  | fetch access outstanding on the bus
// RESP   | valid pulse cycle, no new grant
module mem_port_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  input  logic            d_load,
  input  logic            d_store,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_valid,
  output logic            stall,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_ack,
  output logic            bus_err
);

  typedef enum logic [1:0] {IDLE, BUS_D, BUS_I, RESP} state_t;

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic              d_pend;
  logic              grant_d;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              bus_err_q, bus_err_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  assign d_pend  = d_load | d_store;
  // Alternate on contention: fetch wins only if data won last time.
  assign grant_d = d_pend && (!if_req || !last_d_q);

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (d_pend || if_req) begin
          bus_req_d = 1'b1;
          last_d_d  = grant_d;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
          cnt_d     = '0;
`endif
          if (grant_d) begin
            bus_addr_d  = d_addr;
            bus_we_d    = d_store;
            bus_wdata_d = d_wdata;
            state_d     = BUS_D;
          end else begin
            bus_addr_d  = if_addr;
            bus_we_d    = 1'b0;
            state_d     = BUS_I;
          end
        end
      end
      BUS_D, BUS_I: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          state_d   = RESP;
          if (state_q == BUS_D) begin
            if (!bus_we_q) d_rdata_d = bus_rdata;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = bus_rdata;
            if_valid_d = 1'b1;
          end
        end
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          bus_err_d = 1'b1;
          state_d   = RESP;
          if (state_q == BUS_D) begin
            d_rdata_d = '0;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign stall     = (if_req && !if_valid_q) || (d_pend && !d_valid_q);

endmodule
